// File: rtl/packed_conv_mac_pipe_pkg.sv
// Shared types and helpers for the packed convolution MAC pipeline.
// Holds the per-beat tag struct that travels alongside the data, the
// minimum multiplier depth and the accumulator saturation bound helpers
// (the helpers are only referenced when MAC_SATURATE_EN is defined).
package packed_conv_mac_pkg;

    localparam int MUL_STAGES_MIN = 1;
    // Widest accumulator the saturation bound helpers can describe.
    localparam int SAT_MAX_W      = 64;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
        logic sgn;
    } beat_tag_t;

    // Largest representable accumulator value, right-aligned in SAT_MAX_W bits.
    function automatic logic [SAT_MAX_W-1:0] sat_hi(input int acc_w, input logic sgn);
        logic [SAT_MAX_W-1:0] one;
        one = 1;
        if (sgn) return (one << (acc_w - 1)) - one;
        return (one << acc_w) - one;
    endfunction

    // Smallest representable accumulator value; only the low acc_w bits matter.
    function automatic logic [SAT_MAX_W-1:0] sat_lo(input int acc_w, input logic sgn);
        if (sgn) return ~sat_hi(acc_w, 1'b1);
        return '0;
    endfunction

endpackage

// File: rtl/packed_conv_mac_pipe_if.sv
// Beat/result bus of the packed convolution MAC. The master side drives
// the clock enable and operand beats and observes the group results;
// the slave side is the MAC itself.
interface packed_conv_mac_pipe_if
    import packed_conv_mac_pkg::*;
#(
    parameter int A_W   = 10,
    parameter int B_W   = 10,
    parameter int ACC_W = 32
) ();

    logic             ce;
    logic             in_valid;
    logic             in_first;
    logic             in_last;
    logic             in_signed;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             out_valid;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output ce, in_valid, in_first, in_last, in_signed, in_a, in_b,
        input  out_valid, out_data, out_ovf
    );

    modport slave (
        input  ce, in_valid, in_first, in_last, in_signed, in_a, in_b,
        output out_valid, out_data, out_ovf
    );

endinterface

// File: rtl/packed_conv_mac_pipe_mul.sv
// packed_conv_mac_mul: registered multiplier of MUL_STAGES depth for the
// packed convolution MAC. Each beat chooses signed or unsigned operands
// through its tag; the tag is delayed alongside the product. All
// registers are frozen while i_ce is low; only the tags are reset.
module packed_conv_mac_mul
    import packed_conv_mac_pkg::*;
#(
    parameter int A_W        = 10,
    parameter int B_W        = 10,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_ce,
    input  beat_tag_t        i_tag,
    input  logic [A_W-1:0]   i_a,
    input  logic [B_W-1:0]   i_b,
    output beat_tag_t        o_tag,
    output logic [A_W+B_W-1:0] o_p
);

    localparam int P_W = A_W + B_W;

    // Operands are extended to the full product width so the low P_W bits
    // of the product are exact for both signed and unsigned beats.
    logic               w_sa;
    logic               w_sb;
    logic signed [P_W-1:0] w_a_x;
    logic signed [P_W-1:0] w_b_x;
    logic signed [P_W-1:0] w_prod;

    assign w_sa   = i_tag.sgn & i_a[A_W-1];
    assign w_sb   = i_tag.sgn & i_b[B_W-1];
    assign w_a_x  = $signed({{B_W{w_sa}}, i_a});
    assign w_b_x  = $signed({{A_W{w_sb}}, i_b});
    assign w_prod = w_a_x * w_b_x;

    beat_tag_t        r_tag_pm  [MUL_STAGES];
    logic [P_W-1:0]   r_prod_pm [MUL_STAGES];

    // Stage 1..MUL_STAGES boundary: tag shift register (control, reset).
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < MUL_STAGES; s++) r_tag_pm[s] <= '0;
        end else if (i_ce) begin
            r_tag_pm[0] <= i_tag;
            for (int s = 1; s < MUL_STAGES; s++) r_tag_pm[s] <= r_tag_pm[s-1];
        end
    end

    // Stage 1..MUL_STAGES boundary: product register chain (data, no reset).
    always_ff @(posedge clk) begin
        if (i_ce) begin
            r_prod_pm[0] <= w_prod;
            for (int s = 1; s < MUL_STAGES; s++) r_prod_pm[s] <= r_prod_pm[s-1];
        end
    end

    assign o_tag = r_tag_pm[MUL_STAGES-1];
    assign o_p   = r_prod_pm[MUL_STAGES-1];

endmodule

// File: rtl/packed_conv_mac_pipe.sv
// packed_conv_mac_pipe: ce-stallable pipelined multiply-accumulate for the
// packed convolution datapath. Input register, MUL_STAGES multiplier
// stages, accumulate stage and output stage; latency MUL_STAGES+2.
// One result per first..last group, delivered as a one-ce-cycle pulse.
// Optional feature macro: MAC_SATURATE_EN -- accumulate adds clamp to the
// ACC_W bounds and out_ovf reports a sticky per-group clamp flag. Without
// it the accumulator wraps and out_ovf is tied low.
module packed_conv_mac_pipe
    import packed_conv_mac_pkg::*;
#(
    parameter int A_W        = 10,
    parameter int B_W        = 10,
    parameter int ACC_W      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    packed_conv_mac_pipe_if.slave  bus
);

    localparam int P_W = A_W + B_W;

    if (ACC_W < P_W) begin : g_acc_w_chk
        $error("packed_conv_mac_pipe: ACC_W must be at least A_W+B_W");
    end
    if (MUL_STAGES < MUL_STAGES_MIN) begin : g_mul_stages_chk
        $error("packed_conv_mac_pipe: MUL_STAGES must be at least 1");
    end
`ifdef MAC_SATURATE_EN
    if (ACC_W > SAT_MAX_W) begin : g_sat_w_chk
        $error("packed_conv_mac_pipe: saturation supports ACC_W up to 64");
    end
`endif

    beat_tag_t        r_tag_p0;
    logic [A_W-1:0]   r_a_p0;
    logic [B_W-1:0]   r_b_p0;

    beat_tag_t        w_tag_m;
    logic [P_W-1:0]   w_p_m;

    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [ACC_W-1:0] r_acc_pa;
    logic             r_done_pa;
    logic             r_valid_po;
    logic [ACC_W-1:0] r_data_po;

`ifdef MAC_SATURATE_EN
    logic             w_ovf_nxt;
    logic             r_ovf_pa;
    logic             r_ovf_po;
    logic [ACC_W:0]   w_sat;

    // Accumulate add with clamping; returns {clamped, value}. Signed beats
    // treat acc as two's complement, unsigned beats treat it as unsigned.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] ext,
                                               input logic             sgn);
        logic [ACC_W:0]   sum;
        logic [ACC_W-1:0] hi;
        logic [ACC_W-1:0] lo;
        sum = {1'b0, acc} + {1'b0, ext};
        hi  = ACC_W'(sat_hi(ACC_W, sgn));
        lo  = ACC_W'(sat_lo(ACC_W, sgn));
        if (sgn) begin
            if ((acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]))
                return {1'b1, (acc[ACC_W-1] ? lo : hi)};
        end else if (sum[ACC_W]) begin
            return {1'b1, hi};
        end
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    assign w_sat = sat_add(r_acc_pa, w_ext, w_tag_m.sgn);
`endif

    // Stage 0 boundary: capture beat tags (control, reset).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag_p0 <= '0;
        end else if (bus.ce) begin
            r_tag_p0.vld   <= bus.in_valid;
            r_tag_p0.first <= bus.in_first;
            r_tag_p0.last  <= bus.in_last;
            r_tag_p0.sgn   <= bus.in_signed;
        end
    end

    // Stage 0 boundary: capture operands (data, no reset).
    always_ff @(posedge clk) begin
        if (bus.ce) begin
            r_a_p0 <= bus.in_a;
            r_b_p0 <= bus.in_b;
        end
    end

    packed_conv_mac_mul #(
        .A_W        (A_W),
        .B_W        (B_W),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .i_ce  (bus.ce),
        .i_tag (r_tag_p0),
        .i_a   (r_a_p0),
        .i_b   (r_b_p0),
        .o_tag (w_tag_m),
        .o_p   (w_p_m)
    );

    // Product widened per the beat's own signedness.
    assign w_ext = w_tag_m.sgn ? ACC_W'($signed(w_p_m)) : ACC_W'(w_p_m);

    // Next accumulator value: load on first, add otherwise, hold on bubbles.
    always_comb begin
        w_acc_nxt = r_acc_pa;
`ifdef MAC_SATURATE_EN
        w_ovf_nxt = r_ovf_pa;
`endif
        if (w_tag_m.vld) begin
            if (w_tag_m.first) begin
                w_acc_nxt = w_ext;
`ifdef MAC_SATURATE_EN
                w_ovf_nxt = 1'b0;
`endif
            end else begin
`ifdef MAC_SATURATE_EN
                w_acc_nxt = w_sat[ACC_W-1:0];
                w_ovf_nxt = r_ovf_pa | w_sat[ACC_W];
`else
                w_acc_nxt = r_acc_pa + w_ext;
`endif
            end
        end
    end

    // Accumulate stage boundary: running sum and group-complete tag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc_pa  <= '0;
            r_done_pa <= 1'b0;
`ifdef MAC_SATURATE_EN
            r_ovf_pa  <= 1'b0;
`endif
        end else if (bus.ce) begin
            r_acc_pa  <= w_acc_nxt;
            r_done_pa <= w_tag_m.vld & w_tag_m.last;
`ifdef MAC_SATURATE_EN
            r_ovf_pa  <= w_ovf_nxt;
`endif
        end
    end

    // Output stage boundary: one pulse per group, result held until the next.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_po <= 1'b0;
            r_data_po  <= '0;
`ifdef MAC_SATURATE_EN
            r_ovf_po   <= 1'b0;
`endif
        end else if (bus.ce) begin
            r_valid_po <= r_done_pa;
            if (r_done_pa) begin
                r_data_po <= r_acc_pa;
`ifdef MAC_SATURATE_EN
                r_ovf_po  <= r_ovf_pa;
`endif
            end
        end
    end

    assign bus.out_valid = r_valid_po;
    assign bus.out_data  = r_data_po;
`ifdef MAC_SATURATE_EN
    assign bus.out_ovf   = r_ovf_po;
`else
    assign bus.out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_packed_conv_mac_pipe.sv
// Self-checking bench for packed_conv_mac_pipe: directed groups followed
// by randomized beats, checked against an arithmetic reference model and
// a latency-aware expected-result queue. A second instance with ACC_W=20
// covers accumulator overflow (wrap, or clamp under MAC_SATURATE_EN).
module tb_packed_conv_mac_pipe;

    localparam int A_W = 10;
    localparam int B_W = 10;
    localparam int ACC_W = 32;
    localparam int MS = 2;
    localparam int L = MS + 2;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint UMAX = 64'sd4294967295;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    packed_conv_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus ();
    packed_conv_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(20))    bus2 ();

    packed_conv_mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .MUL_STAGES(MS)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    packed_conv_mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(20), .MUL_STAGES(MS)) dut20 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        int          age;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_acc;
    logic        m_ovf;
    logic        prev_valid;
    logic [31:0] held;
    int          pulses;
    int          n_cmp;
    int          n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
        end
    endtask

    // Reference: dot product by plain integer arithmetic, ACC_W=32 bounds.
    task automatic model_beat(input logic f, input logic l, input logic s,
                              input logic [9:0] a, input logic [9:0] b);
        longint p;
        longint sum;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'(a) * longint'(b);
        if (f) begin
            sum   = p;
            m_ovf = 1'b0;
        end else begin
            if (s) sum = longint'($signed(m_acc)) + p;
            else   sum = longint'(m_acc) + p;
`ifdef MAC_SATURATE_EN
            if (s && sum > SMAX) begin sum = SMAX; m_ovf = 1'b1; end
            if (s && sum < SMIN) begin sum = SMIN; m_ovf = 1'b1; end
            if (!s && sum > UMAX) begin sum = UMAX; m_ovf = 1'b1; end
`endif
        end
        m_acc = sum[31:0];
        if (l) q.push_back('{data: m_acc, ovf: m_ovf, age: 0});
    endtask

    // One clock with the given beat and ce; outputs checked #1 after the edge.
    task automatic cyc(input logic v, input logic f, input logic l, input logic s,
                       input logic [9:0] a, input logic [9:0] b, input logic c);
        logic exp_v;
        bus.ce = c; bus.in_valid = v; bus.in_first = f; bus.in_last = l;
        bus.in_signed = s; bus.in_a = a; bus.in_b = b;
        @(posedge clk);
        #1;
        if (c) begin
            foreach (q[i]) q[i].age++;
            if (v) model_beat(f, l, s, a, b);
            exp_v = (q.size() > 0) && (q[0].age == L);
            check("out_valid", 64'(bus.out_valid), 64'(exp_v));
            if (exp_v) begin
                check("out_data", 64'(bus.out_data), 64'(q[0].data));
                check("out_ovf", 64'(bus.out_ovf), 64'(q[0].ovf));
                held = q[0].data;
                pulses++;
                void'(q.pop_front());
            end else begin
                check("out_data_hold", 64'(bus.out_data), 64'(held));
            end
        end else begin
            check("stall_valid_hold", 64'(bus.out_valid), 64'(prev_valid));
            check("stall_data_hold", 64'(bus.out_data), 64'(held));
        end
        prev_valid = bus.out_valid;
    endtask

    task automatic rst_cyc(input logic c);
        reset = 1'b0;
        bus.ce = c; bus.in_valid = 1'b1; bus.in_first = 1'b0; bus.in_last = 1'b1;
        bus.in_signed = 1'b0; bus.in_a = 10'($urandom); bus.in_b = 10'($urandom);
        @(posedge clk);
        #1;
        q.delete();
        m_acc = '0; m_ovf = 1'b0; held = '0; prev_valid = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        reset = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
    endtask

    initial begin
        int p0;
        int waited;
        logic seen;
        n_cmp = 0; n_fail = 0; pulses = 0;
        m_acc = '0; m_ovf = 1'b0; held = '0; prev_valid = 1'b0;
        reset = 1'b0;
        bus2.ce = 1'b1; bus2.in_valid = 1'b0; bus2.in_first = 1'b0; bus2.in_last = 1'b0;
        bus2.in_signed = 1'b0; bus2.in_a = '0; bus2.in_b = '0;

        rst_cyc(1'b1);
        rst_cyc(1'b0);

        // Single unsigned beat 1023*1023.
        p0 = pulses;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd1023, 10'd1023, 1'b1);
        idle(L + 1);
        check("single_pulses", 64'(pulses - p0), 64'd1);
        check("single_result", 64'(held), 64'd1046529);

        // Signed group (-3*5) + (7*2) = -1.
        p0 = pulses;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 10'h3FD, 10'd5, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 10'd7, 10'd2, 1'b1);
        idle(L + 1);
        check("signed_pulses", 64'(pulses - p0), 64'd1);
        check("signed_result", 64'(held), 64'hFFFF_FFFF);

        // Three beats with a bubble and a 5-cycle ce stall.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 10'd100, 10'd200, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'd999, 10'd999, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 10'd77, 10'd77, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'd5, 10'd6, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd7, 10'd8, 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        idle(L);
        check("stall_result", 64'(held), 64'd20086);

        // Back-to-back groups: 100+1 then 6+20.
        p0 = pulses;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 10'd10, 10'd10, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd1, 10'd1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 10'd2, 10'd3, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd4, 10'd5, 1'b1);
        idle(L + 1);
        check("b2b_pulses", 64'(pulses - p0), 64'd2);
        check("b2b_second", 64'(held), 64'd26);

        // Reset mid-group discards the partial sum; then 2*3.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 10'd50, 10'd50, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd9, 10'd9, 1'b1);
        rst_cyc(1'b1);
        p0 = pulses;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 10'd2, 10'd3, 1'b1);
        idle(L + 2);
        check("post_rst_pulses", 64'(pulses - p0), 64'd1);
        check("post_rst_result", 64'(held), 64'd6);

        // Non-first beat straight after reset accumulates onto zero.
        rst_cyc(1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd3, 10'd4, 1'b1);
        idle(L + 1);
        check("after_rst_nofirst", 64'(held), 64'd12);

        // Randomized beats, stalls, bubbles and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                rst_cyc(1'($urandom_range(0, 1)));
            end else begin
                cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    10'($urandom), 10'($urandom), 1'($urandom_range(0, 9) != 0));
            end
        end
        idle(L + 2);
        check("queue_drained", 64'(q.size()), 64'd0);

        // ACC_W=20 instance: 1023*1023 twice overflows 20 bits.
        bus2.in_valid = 1'b1; bus2.in_first = 1'b1; bus2.in_last = 1'b0;
        bus2.in_a = 10'd1023; bus2.in_b = 10'd1023;
        @(posedge clk); #1;
        bus2.in_first = 1'b0; bus2.in_last = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 12) begin
            @(posedge clk); #1;
            waited++;
            seen = bus2.out_valid;
        end
        check("acc20_seen", 64'(seen), 64'd1);
        check("acc20_latency", 64'(waited), 64'(L));
`ifdef MAC_SATURATE_EN
        check("acc20_data", 64'(bus2.out_data), 64'd1048575);
        check("acc20_ovf", 64'(bus2.out_ovf), 64'd1);
`else
        check("acc20_data", 64'(bus2.out_data), 64'd1044482);
        check("acc20_ovf", 64'(bus2.out_ovf), 64'd0);
`endif
        @(posedge clk); #1;
        check("acc20_pulse_end", 64'(bus2.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/packed_conv_mac_pipe.md
# packed_conv_mac_pipe

Parametrised, ce-stallable pipelined multiply-accumulate unit for the packed convolution datapath. It generalises the fixed 10x10 unsigned 4-stage DSP multiplier: operand widths, multiplier depth and accumulator width are parameters, signed/unsigned mode is selected per beat, and valid/first/last tags travel with each beat. It sits between the line-buffer/weight fetch and the output-channel writeback and produces one dot-product result per first..last group.

## Interface
- A_W, 10, operand A width
- B_W, 10, operand B width
- ACC_W, 32, accumulator/result width; elaboration error if ACC_W < A_W+B_W
- MUL_STAGES, 2, registered multiplier stages (>=1); total latency L = MUL_STAGES+2
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- ce  in  1  clock enable; low freezes every register
- in_valid  in  1  beat present
- in_first  in  1  beat opens a new accumulation group
- in_last  in  1  beat closes the group
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_a  in  A_W  operand A
- in_b  in  B_W  operand B
- out_valid  out  1  out_data holds a completed group result
- out_data  out  ACC_W  accumulated result
- out_ovf  out  1  group overflowed (saturated); see Configuration

## Operation
- Stage 0: register in_a, in_b and tags (valid, first, last, signed).
- Stages 1..MUL_STAGES: product P = a*b, full A_W+B_W bits, signedness from tag; tags shifted alongside.
- Accumulate stage: P sign-extended (signed) or zero-extended (unsigned) to ACC_W. If valid&first: acc <= ext(P); if valid&!first: acc <= acc+ext(P); if !valid: acc unchanged.
- Output stage: when accumulating beat has last: out_data <= new acc, out_valid <= 1; otherwise out_valid <= 0, out_data holds previous value.
- first&last on same beat: single-product group, result = ext(P).
- Mixed signedness within a group is legal; each product uses its own beat's tag.
- Beat with !first after reset accumulates onto acc = 0.
- Bubbles (in_valid=0) inside a group are allowed and do not disturb acc.
- Overflow without MAC_SATURATE_EN: wrap modulo 2^ACC_W.

## Timing
- Reset (reset=0 at clk edge, overrides ce): all tag valids 0, acc 0, out_valid 0, out_data 0, out_ovf 0. Mid-group reset discards partial sum; in-flight beats are lost.
- Latency: beat with in_last sampled at edge n (ce=1 throughout) -> out_valid=1 after edge n+L (default L=4).
- Throughput: one beat per ce-high cycle, no back-pressure.
- ce=0: no register updates; outputs hold, including out_valid=1 (consumer must qualify with ce).
- out_valid is a single-cycle (single ce-high cycle) pulse per group.

## Configuration
- MAC_SATURATE_EN defined: accumulate adds clamp to ACC_W bounds (signed: -2^(ACC_W-1)..2^(ACC_W-1)-1 when the beat's tag is signed; unsigned: 0..2^ACC_W-1). A sticky group flag sets on any clamp, cleared on first; out_ovf = flag value at the group's last beat, valid with out_valid.
- Not defined: wrap arithmetic, out_ovf tied 0, no clamp logic generated.

## Structure
- Package packed_conv_mac_pkg: beat-tag struct (valid, first, last, signed), ACC_W-width saturation bound helper functions, MUL_STAGES minimum constant.
- Sub-module packed_conv_mac_mul: registered signed/unsigned multiplier of MUL_STAGES depth carrying the tag struct, ce-gated; top adds input, accumulate and output stages.

## Test plan
- Single beat unsigned a=1023, b=1023, first=last=1 -> after 4 cycles out_valid=1, out_data=1046529.
- Signed group a=-3,b=5 then a=7,b=2 (first, last) -> out_data = 32'hFFFF_FFFF (-1), one pulse.
- Group of 3 beats with ce=0 for 5 cycles in the middle and one in_valid=0 bubble -> same sum as uninterrupted, latency extended by 5 stalled cycles.
- Back-to-back groups (last then first on consecutive cycles) -> two consecutive out_valid pulses, second result independent of first.
- reset=0 mid-group for 1 cycle, then new group 2*3 first/last -> outputs 0 during reset, no stale result, then out_data=6.
- ACC_W=20, unsigned 1023*1023 twice: without macro out_data=1044482 (wrap), out_ovf=0; with MAC_SATURATE_EN out_data=1048575, out_ovf=1.
